serial_add_ctrl: RTL and testbench

Bit-serial add/subtract sequencer for the CPU datapath. It drives a single `fulladder` cell one bit per clock over WIDTH cycles, holding the carry in a flip-flop between bits. It exposes a start/done handshake to the issuing control logic and produces the result and NZCV-style flags. It is used where a full WIDTH-bit ripple adder is too costly, for example in multi-cycle address or loop-count updates.

---
 rtl/serial_add_ctrl.sv | 141 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer, one fulladder bit per clock.
// Ports: clk, reset (async, high) | start, sub, a, b in | busy, done, result, carry_out, overflow, zero, negative out.
// Macro SERIAL_ADD_SUB_EN enables subtraction; when undefined sub is ignored.

module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, nxt;

  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic [CW-1:0]    cnt;
  logic             carry_ff, prev_carry;
  logic             fa_s, fa_co;
  logic             last;
  logic             sub_en;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_en = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign sub_en     = 1'b0;
`endif

  fulladder u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry_ff),
    .s   (fa_s),
    .cout(fa_co)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (last)  nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh       <= '0;
      b_sh       <= '0;
      r_sh       <= '0;
      cnt        <= '0;
      carry_ff   <= 1'b0;
      prev_carry <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh     <= a;
            b_sh     <= sub_en ? ~b : b;
            carry_ff <= sub_en;
            cnt      <= '0;
          end
        end
        RUN: begin
          // LSB-first: each sum bit enters at the top and walks down
          r_sh     <= {fa_s, r_sh[WIDTH-1:1]};
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          carry_ff <= fa_co;
          cnt      <= cnt + 1'b1;
          // carry into the MSB, needed for signed overflow
          if (last) prev_carry <= carry_ff;
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered; result and flags only change
  // when a completed operation leaves DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
    end else begin
      busy <= (nxt != IDLE);
      done <= (state == DONE);
      if (state == DONE) begin
        result    <= r_sh;
        carry_out <= carry_ff;
        overflow  <= prev_carry ^ carry_ff;
        zero      <= (r_sh == '0);
        negative  <= r_sh[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: self-checking bench for serial_add_ctrl.
// Runs an 8-bit and a 64-bit instance against an arithmetic reference model.

module tb_serial_add_ctrl;

`ifdef SERIAL_ADD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, res8;
  logic       busy8, done8, c8, v8, z8, n8;

  logic        start64 = 1'b0, sub64 = 1'b0;
  logic [63:0] a64 = '0, b64 = '0, res64;
  logic        busy64, done64, c64, v64, z64, n64;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .sub(sub8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .result(res8),
    .carry_out(c8), .overflow(v8), .zero(z8), .negative(n8)
  );

  serial_add_ctrl #(.WIDTH(64)) dut64 (
    .clk(clk), .reset(reset), .start(start64), .sub(sub64),
    .a(a64), .b(b64), .busy(busy64), .done(done64), .result(res64),
    .carry_out(c64), .overflow(v64), .zero(z64), .negative(n64)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] r;
    logic       c;
    logic       v;
    logic       z;
    logic       n;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain (w+1)-bit arithmetic, sub as a + ~b + 1.
  task automatic model(input int w, input logic [63:0] ia, ib,
                       input logic is, output logic [63:0] r,
                       output logic c, v, z, n);
    logic [64:0] full;
    logic [63:0] mask, aa, bb;
    logic        eff;
    eff  = is & SUB_EN;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa   = ia & mask;
    bb   = (eff ? ~ib : ib) & mask;
    full = {1'b0, aa} + {1'b0, bb} + {64'd0, eff};
    r    = full[63:0] & mask;
    c    = full[w];
    n    = r[w-1];
    v    = (aa[w-1] == bb[w-1]) && (n != aa[w-1]);
    z    = (r == 64'd0);
  endtask

  task automatic op8(input logic [7:0] ia, ib, input logic is,
                     output int lat);
    @(negedge clk);
    a8 = ia; b8 = ib; sub8 = is; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic op64(input logic [63:0] ia, ib, input logic is,
                      output int lat);
    @(negedge clk);
    a64 = ia; b64 = ib; sub64 = is; start64 = 1'b1;
    @(posedge clk);
    #1 start64 = 1'b0;
    lat = 0;
    while (!done64 && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  initial begin
    int          lat, ghost;
    logic [63:0] er;
    logic        ec, ev, ez, en;
    logic [7:0]  ra, rb;
    logic        rs;

    tbl[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0};
    if (SUB_EN) begin
      tbl[5] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[6] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
    end else begin
      tbl[5] = '{8'h05, 8'h07, 1'b1, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{8'h80, 8'h01, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1};
    end

    // reset state
    #2 reset = 1'b1;
    #1;
    chk("rst8", {busy8, done8, res8, c8, v8, z8, n8}, 64'd0);
    chk("rst64", {busy64, done64, c64, v64, z64, n64}, 64'd0);
    chk("rst64_res", res64, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    // directed table
    for (int i = 0; i < 7; i++) begin
      op8(tbl[i].a, tbl[i].b, tbl[i].s, lat);
      chk($sformatf("lat[%0d]", i), 64'(lat), 64'd9);
      chk($sformatf("res[%0d]", i), {56'd0, res8}, {56'd0, tbl[i].r});
      chk($sformatf("c[%0d]", i), {63'd0, c8}, {63'd0, tbl[i].c});
      chk($sformatf("v[%0d]", i), {63'd0, v8}, {63'd0, tbl[i].v});
      chk($sformatf("z[%0d]", i), {63'd0, z8}, {63'd0, tbl[i].z});
      chk($sformatf("n[%0d]", i), {63'd0, n8}, {63'd0, tbl[i].n});
      @(posedge clk);
      #1 chk($sformatf("pulse[%0d]", i), {63'd0, done8}, 64'd0);
    end

    // start held through RUN and DONE: one done, then restart in IDLE
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 a8 = 8'hFF; b8 = 8'hFF;
    chk("busy_run", {63'd0, busy8}, 64'd1);
    lat = 0;
    while (!done8 && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("hold_lat", 64'(lat), 64'd9);
    chk("hold_res", {56'd0, res8}, 64'h30);
    @(posedge clk);
    #1 start8 = 1'b0;
    chk("hold_pulse", {63'd0, done8}, 64'd0);
    chk("restart_busy", {63'd0, busy8}, 64'd1);
    lat = 0;
    while (!done8 && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("restart_lat", 64'(lat), 64'd9);
    chk("restart_res", {56'd0, res8}, 64'hFE);
    chk("restart_c", {63'd0, c8}, 64'd1);

    // reset during bit 3
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h0F; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1 chk("midrst", {busy8, done8, res8, c8, v8, z8, n8}, 64'd0);
    @(negedge clk) reset = 1'b0;
    ghost = 0;
    repeat (12) begin
      @(posedge clk);
      #1 if (done8) ghost++;
    end
    chk("no_ghost_done", 64'(ghost), 64'd0);
    op8(8'h10, 8'h20, 1'b0, lat);
    chk("post_rst_lat", 64'(lat), 64'd9);
    chk("post_rst_res", {56'd0, res8}, 64'h30);

    // random 8-bit against the model
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      model(8, {56'd0, ra}, {56'd0, rb}, rs, er, ec, ev, ez, en);
      op8(ra, rb, rs, lat);
      chk($sformatf("rnd_lat[%0d]", i), 64'(lat), 64'd9);
      chk($sformatf("rnd_flags[%0d] %h%s%h", i, ra, rs ? "-" : "+", rb),
          {51'd0, res8, c8, v8, z8, n8}, {51'd0, er[7:0], ec, ev, ez, en});
    end

    // 64-bit boundary and random
    op64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat);
    chk("w64_lat", 64'(lat), 64'd65);
    chk("w64_res", res64, 64'h8000_0000_0000_0000);
    chk("w64_flags", {60'd0, c64, v64, z64, n64}, 64'b0101);
    for (int i = 0; i < 6; i++) begin
      a64 = {$urandom, $urandom};
      b64 = {$urandom, $urandom};
      rs  = 1'($urandom);
      model(64, a64, b64, rs, er, ec, ev, ez, en);
      op64(a64, b64, rs, lat);
      chk($sformatf("w64_rnd_lat[%0d]", i), 64'(lat), 64'd65);
      chk($sformatf("w64_rnd_res[%0d]", i), res64, er);
      chk($sformatf("w64_rnd_flags[%0d]", i), {60'd0, c64, v64, z64, n64},
          {60'd0, ec, ev, ez, en});
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
